multicycle_decoder: RTL
=======================

Name: multicycle_decoder

Overview:
- Control-unit decoder for the multicycle variant of the processor.
- Decodes Op/Funct/Rd of the fetched instruction and sequences FETCH→…→FETCH through a Moore FSM.
- Drives the datapath selects, plus the raw RegW/MemW/PCS/FlagW/NoWrite that the conditional-write logic gates with CondEx.
- Sits between the instruction register and the condition/flag unit.

Parameters:
- ALUCTL_W, 2, width of ALUControl.
- STATE_W, 4, width of state register (10 states used).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; forces state to FETCH.
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20]: [5]=I, [4:1]=cmd, [0]=S (or L for memory ops).
- Rd  in  4  destination register field.
- IRWrite  out  1  instruction register load.
- AdrSrc  out  1  memory address select: 0=PC, 1=Result.
- ALUSrcA  out  1  0=Rn, 1=PC.
- ALUSrcB  out  2  00=reg, 01=ExtImm, 10=constant 4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- NextPC  out  1  unconditional PC write (fetch).
- ImmSrc  out  2  equals Op.
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01).
- ALUControl  out  ALUCTL_W  00=ADD, 01=SUB, 10=AND, 11=ORR.
- FlagW  out  2  [1]=NZ write, [0]=CV write.
- RegW, MemW, PCS, NoWrite  out  1 each  raw, ungated write requests to the condition unit.

Behaviour:
- Moore FSM. Outputs are a pure function of state, except these, which are combinational from the current inputs:
  - ImmSrc and RegSrc.
  - ALUControl, FlagW and NoWrite (decoded only when ALUOp=1).
  - PCS.
- After reset deasserts: state=FETCH; IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; all other outputs 0 (ALUControl=00, FlagW=00).
- Transitions, one per clock:
  - FETCH→DECODE.
  - DECODE:
    - Op=01→MEMADR.
    - Op=00, I=0→EXECUTER.
    - Op=00, I=1→EXECUTEI.
    - Op=10→BRANCH.
    - Op=11 (undefined)→FETCH, with no write issued.
  - MEMADR: L=1→MEMRD, L=0→MEMWR.
  - MEMRD→MEMWB→FETCH.
  - MEMWR→FETCH.
  - EXECUTER→ALUWB, EXECUTEI→ALUWB.
  - ALUWB→FETCH.
  - BRANCH→FETCH.
- State outputs (unlisted signals are 0; ALUOp is internal):
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECUTER: ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0: ALUControl=00, FlagW=00, NoWrite=0.
  - ALUOp=1, by cmd:
    - 0100 ADD→00
    - 0010 SUB→01
    - 0000 AND→10
    - 1100 ORR→11
    - 1010 CMP→01 with NoWrite=1
    - any other cmd→ALUControl=00, NoWrite=1, FlagW=00
  - For legal cmds, flag writes depend on S: FlagW[1]=S; FlagW[0]=S & cmd∈{ADD,SUB,CMP}. CMP without S still has NoWrite=1.
- PCS = Branch | (RegW & Rd==4'hF).
- Latency per instruction class:
  - branch: 3 cycles
  - data-processing: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
- Reset asserted mid-instruction: state returns to FETCH immediately (asynchronously); no write outputs are asserted while reset is low.
- Unreachable state encodings →FETCH on next clock, with FETCH outputs.

Decomposition:
- Shared package holds:
  - state enumeration;
  - Op constants (DP=00, MEM=01, BR=10);
  - cmd constants (ADD, SUB, AND, ORR, CMP);
  - ALUControl codes;
  - ALUSrcB and ResultSrc select codes.
- One combinational sub-module, alu_decoder: inputs ALUOp, Funct[4:0]; outputs ALUControl, FlagW, NoWrite.

Test Plan:
- Hold reset low, then release: FETCH outputs (IRWrite=1, NextPC=1, ALUSrcB=10, ResultSrc=10). Next cycle DECODE: IRWrite=0, NextPC=0.
- Op=00, Funct=001001 (ADDS, register), Rd=3: EXECUTER with ALUControl=00, FlagW=11; then ALUWB with RegW=1, PCS=0; FETCH on cycle 5.
- Op=00, Funct=110101 (CMP imm, S=1): EXECUTEI with ALUSrcB=01, ALUControl=01, FlagW=11, NoWrite=1; ALUWB RegW=1.
- Op=01, L=1, Rd=15 (LDR to PC): MEMADR(ALUSrcB=01) → MEMRD(AdrSrc=1) → MEMWB(ResultSrc=01, RegW=1, PCS=1). With L=0: MEMWR, MemW=1, back to FETCH in 4 cycles total.
- Op=10: BRANCH with Branch-derived PCS=1, ALUSrcB=01, ResultSrc=10; FETCH next. Op=11: DECODE→FETCH, RegW, MemW and PCS stay 0.
- Assert reset during MEMRD: outputs take FETCH values at once, before the next clock edge; after release the sequence restarts from FETCH.

Source files
------------

// File: rtl/multicycle_decoder_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encoding,
// instruction field constants, datapath select codes and the per-state
// control bundle with its decode function.
package multicycle_decoder_pkg;

  localparam int unsigned STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // Op field (instruction bits [27:26])
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Data-processing cmd field (Funct[4:1])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ALUControl codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // ALUSrcB select codes
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ResultSrc select codes
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Moore outputs that depend on state only
  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c           = '0;
    c.alusrcb   = SRCB_REG;
    c.resultsrc = RES_ALUOUT;
    case (s)
      S_DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = SRCB_FOUR;
        c.resultsrc = RES_ALURESULT;
      end
      S_MEMADR:   c.alusrcb = SRCB_IMM;
      S_MEMRD:    c.adrsrc  = 1'b1;
      S_MEMWB: begin
        c.resultsrc = RES_DATA;
        c.regw      = 1'b1;
      end
      S_MEMWR: begin
        c.adrsrc = 1'b1;
        c.memw   = 1'b1;
      end
      S_EXECUTER: c.aluop = 1'b1;
      S_EXECUTEI: begin
        c.alusrcb = SRCB_IMM;
        c.aluop   = 1'b1;
      end
      S_ALUWB:    c.regw = 1'b1;
      S_BRANCH: begin
        c.alusrcb   = SRCB_IMM;
        c.resultsrc = RES_ALURESULT;
        c.branch    = 1'b1;
      end
      default: begin
        // FETCH, and any encoding outside the enumeration
        c.irwrite   = 1'b1;
        c.alusrca   = 1'b1;
        c.alusrcb   = SRCB_FOUR;
        c.resultsrc = RES_ALURESULT;
        c.nextpc    = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_decoder_alu_decoder.sv
// ALU decoder: maps the data-processing cmd and S bit to ALUControl,
// flag-write enables and the NoWrite (compare / unsupported) request.
//   ALUOp      in  decode enable from the main FSM
//   Funct      in  [4:1]=cmd, [0]=S
//   ALUControl out 00=ADD 01=SUB 10=AND 11=ORR
//   FlagW      out [1]=NZ write, [0]=CV write
//   NoWrite    out suppress register write-back
module alu_decoder
  import multicycle_decoder_pkg::*;
(
  input  logic       ALUOp,
  input  logic [4:0] Funct,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       NoWrite
);

  logic [3:0] cmd;
  logic       s;

  assign cmd = Funct[4:1];
  assign s   = Funct[0];

  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = '0;
    NoWrite    = 1'b0;
    if (ALUOp) begin
      case (cmd)
        CMD_ADD: begin
          ALUControl = ALU_ADD;
          FlagW      = {s, s};
        end
        CMD_SUB: begin
          ALUControl = ALU_SUB;
          FlagW      = {s, s};
        end
        CMD_AND: begin
          ALUControl = ALU_AND;
          FlagW      = {s, 1'b0};
        end
        CMD_ORR: begin
          ALUControl = ALU_ORR;
          FlagW      = {s, 1'b0};
        end
        CMD_CMP: begin
          ALUControl = ALU_SUB;
          FlagW      = {s, s};
          NoWrite    = 1'b1;
        end
        default: NoWrite = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_decoder.sv
// Multicycle control-unit decoder. Moore FSM sequencing FETCH..FETCH with
// registered state outputs; ImmSrc/RegSrc/ALU decode/PCS follow the current
// instruction fields combinationally.
//   clk, reset(active-low async)
//   Op, Funct, Rd                        instruction fields
//   IRWrite AdrSrc ALUSrcA ALUSrcB ResultSrc NextPC ImmSrc RegSrc ALUControl
//   FlagW                                datapath controls
//   RegW MemW PCS NoWrite                raw write requests to condition unit
module multicycle_decoder
  import multicycle_decoder_pkg::*;
#(
  parameter int unsigned ALUCTL_W = 2,
  parameter int unsigned STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic [3:0]          Rd,
  output logic                IRWrite,
  output logic                AdrSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ResultSrc,
  output logic                NextPC,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [1:0]          FlagW,
  output logic                RegW,
  output logic                MemW,
  output logic                PCS,
  output logic                NoWrite
);

  logic [STATE_W-1:0] state_q;
  state_t             state;
  state_t             state_nxt;
  ctrl_t              ctrl_q;
  logic [1:0]         alu_ctl;

  assign state = state_t'(state_q);

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_nxt = S_MEMADR;
          OP_DP:   state_nxt = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_nxt = S_BRANCH;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_nxt = S_MEMWB;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register; async reset loads FETCH outputs immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STATE_W'(S_FETCH);
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= STATE_W'(state_nxt);
      ctrl_q  <= state_ctrl(state_nxt);
    end
  end

  alu_decoder u_alu_decoder (
    .ALUOp      (ctrl_q.aluop),
    .Funct      (Funct[4:0]),
    .ALUControl (alu_ctl),
    .FlagW      (FlagW),
    .NoWrite    (NoWrite)
  );

  assign IRWrite    = ctrl_q.irwrite;
  assign AdrSrc     = ctrl_q.adrsrc;
  assign ALUSrcA    = ctrl_q.alusrca;
  assign ALUSrcB    = ctrl_q.alusrcb;
  assign ResultSrc  = ctrl_q.resultsrc;
  assign NextPC     = ctrl_q.nextpc;
  assign RegW       = ctrl_q.regw;
  assign MemW       = ctrl_q.memw;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == OP_MEM, Op == OP_BR};
  assign ALUControl = ALUCTL_W'(alu_ctl);
  assign PCS        = ctrl_q.branch | (ctrl_q.regw & (Rd == 4'hF));

endmodule
